// File: rtl/key_debounce.sv
// key_debounce
//
// Multi-channel push-button conditioner. Each raw key bit is synchronised
// (two flops), normalised so that 1 means "pressed", and debounced with a
// stable-count filter. Every channel then yields a clean level, one-cycle
// press/release pulses, and a one-shot long-press pulse.
//
// Parameters:
//   NUM_KEYS      number of independent channels
//   STABLE_CYCLES consecutive cycles a new value must hold to be accepted (>= 1)
//   LONG_CYCLES   cycles of continuous pressed level before key_long (0 = off)
//   ACTIVE_LOW    1: raw 0 is pressed; 0: raw 1 is pressed
//
// Ports:
//   CLOCK_50     system clock, rising edge
//   rst_n        synchronous active-low reset
//   key_in       raw asynchronous key inputs
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse on key_level rising
//   key_release  one-cycle pulse on key_level falling
//   key_long     one-cycle pulse once per press after LONG_CYCLES held
module key_debounce #(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned STABLE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic                CLOCK_50,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  // Counter widths, clamped to at least one bit so a disabled long-press
  // counter still has a legal declaration.
  localparam int DB_RAW_W = $clog2(STABLE_CYCLES + 1);
  localparam int LP_RAW_W = $clog2(LONG_CYCLES + 1);
  localparam int DBW      = (DB_RAW_W < 1) ? 1 : DB_RAW_W;
  localparam int LPW      = (LP_RAW_W < 1) ? 1 : LP_RAW_W;

  localparam bit            LONG_EN      = (LONG_CYCLES != 0);
  localparam logic          RELEASED_RAW = (ACTIVE_LOW != 0);
  localparam logic [DBW-1:0] DB_LAST     = DBW'(STABLE_CYCLES - 1);
  localparam logic [LPW-1:0] LP_LAST     = LPW'(LONG_EN ? LONG_CYCLES - 1 : 0);

  // Synchroniser, shared register for all channels. Reset loads the
  // "released" raw value so no phantom press is seen after reset.
  logic [NUM_KEYS-1:0] s1_q, s2_q;

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      s1_q <= {NUM_KEYS{RELEASED_RAW}};
      s2_q <= {NUM_KEYS{RELEASED_RAW}};
    end else begin
      s1_q <= key_in;
      s2_q <= s1_q;
    end
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
    logic           pressed;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic [LPW-1:0] lp_cnt_q, lp_cnt_d;
    logic           lp_done_q, lp_done_d;
    logic           long_q, long_d;

    // Normalised sample: 1 = pressed regardless of board polarity.
    assign pressed = s2_q[k] ^ RELEASED_RAW;

    // Debouncer: any agreement with the current level restarts the count,
    // so a bounce back never flips the level.
    always_comb begin
      db_cnt_d  = db_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (pressed == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
        level_d   = pressed;
        db_cnt_d  = '0;
        press_d   = pressed;
        release_d = ~pressed;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end

    // Long-press timer works on the registered level; lp_done latches after
    // the pulse so a key held forever fires only once.
    always_comb begin
      lp_cnt_d  = lp_cnt_q;
      lp_done_d = lp_done_q;
      long_d    = 1'b0;
      if (!LONG_EN || !level_q) begin
        lp_cnt_d  = '0;
        lp_done_d = 1'b0;
      end else if (!lp_done_q) begin
        if (lp_cnt_q == LP_LAST) begin
          long_d    = 1'b1;
          lp_done_d = 1'b1;
        end else begin
          lp_cnt_d = lp_cnt_q + LPW'(1);
        end
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        lp_cnt_q  <= '0;
        lp_done_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        lp_cnt_q  <= lp_cnt_d;
        lp_done_q <= lp_done_d;
        long_q    <= long_d;
      end
    end

    assign key_level[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = release_q;
    assign key_long[k]    = long_q;

    // A flip is either up or down, never both.
    a_press_release_excl : assert property (@(posedge CLOCK_50) !(press_q && release_q));
  end

endmodule

// File: tb/tb_key_debounce.sv
module tb_key_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] key_in;
  logic [3:0] key_level, key_press, key_release, key_long;
  logic [3:0] key_in2;
  logic [3:0] level2, press2, release2, long2;

  always #5 clk = ~clk;

  key_debounce #(
    .NUM_KEYS(4), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(1)
  ) u_dut (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  // Active-high polarity instance.
  key_debounce #(
    .NUM_KEYS(4), .STABLE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_LOW(0)
  ) u_dut_hi (
    .CLOCK_50   (clk),
    .rst_n      (rst_n),
    .key_in     (key_in2),
    .key_level  (level2),
    .key_press  (press2),
    .key_release(release2),
    .key_long   (long2)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] key;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
    logic [3:0] lng;
  } vec_t;

  vec_t vecs[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic add(input logic r, input logic [3:0] k, input logic [3:0] l,
                     input logic [3:0] p, input logic [3:0] rl, input logic [3:0] lg);
    vec_t v;
    v.rst_n = r; v.key = k; v.lvl = l; v.prs = p; v.rel = rl; v.lng = lg;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int longs;
    int rels;
    logic [3:0] bounce [20];

    rst_n   = 1'b0;
    key_in  = 4'hF;
    key_in2 = 4'h0;

    // Reset, idle, then a clean press/release on channel 0.
    for (int i = 0; i < 3; i++)  add(0, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) add(1, 4'hF, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)  add(1, 4'hE, 0, 0, 0, 0);
    add(1, 4'hE, 4'h1, 4'h1, 0, 0);
    for (int i = 0; i < 3; i++)  add(1, 4'hE, 4'h1, 0, 0, 0);
    for (int i = 0; i < 5; i++)  add(1, 4'hF, 4'h1, 0, 0, 0);
    add(1, 4'hF, 0, 0, 4'h1, 0);
    for (int i = 0; i < 3; i++)  add(1, 4'hF, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      rst_n  = vecs[i].rst_n;
      key_in = vecs[i].key;
      step();
      check($sformatf("vec%0d", i), {key_level, key_press, key_release, key_long},
            {vecs[i].lvl, vecs[i].prs, vecs[i].rel, vecs[i].lng});
    end

    // Bounce on channel 1: lows of 3 and 3 cycles are too short to accept.
    for (int i = 0; i < 20; i++) bounce[i] = 4'hF;
    for (int i = 0; i < 3; i++) bounce[i] = 4'hD;
    for (int i = 5; i < 8; i++) bounce[i] = 4'hD;
    for (int i = 0; i < 20; i++) begin
      key_in = bounce[i];
      step();
      check($sformatf("bounce%0d", i), {13'd0, key_level[1], key_press[1], key_release[1]}, 16'd0);
    end

    // Long press on channel 2 held well past the long-press delay.
    key_in = 4'hB;
    for (int i = 0; i < 5; i++) begin
      step();
      check("lp_pre", {15'd0, key_press[2]}, 16'd0);
    end
    step();
    check("lp_press", {14'd0, key_level[2], key_press[2]}, 16'd3);
    for (int i = 1; i < 10; i++) begin
      step();
      check("lp_wait", {15'd0, key_long[2]}, 16'd0);
    end
    step();
    check("lp_fire", {14'd0, key_level[2], key_long[2]}, 16'd3);
    longs = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      longs += int'(key_long[2]);
    end
    check("lp_once", 16'(longs), 16'd0);
    check("lp_held", {15'd0, key_level[2]}, 16'd1);
    key_in = 4'hF;
    for (int i = 0; i < 5; i++) step();
    step();
    check("lp_release", {14'd0, key_level[2], key_release[2]}, 16'd1);
    step();

    // Short press: raw release sampled 7 edges after raw press sample.
    key_in = 4'hB;
    for (int i = 0; i < 5; i++) step();
    step();
    check("sp_press", {15'd0, key_press[2]}, 16'd1);
    step();
    key_in = 4'hF;
    longs = 0;
    rels  = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      longs += int'(key_long[2]);
      rels  += int'(key_release[2]);
    end
    check("sp_nolong", 16'(longs), 16'd0);
    check("sp_rel", 16'(rels), 16'd1);

    // Simultaneous press on all channels.
    key_in = 4'h0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("sim_pre", {12'd0, key_press}, 16'd0);
    end
    step();
    check("sim_press", {8'd0, key_level, key_press}, 16'hFF);
    key_in = 4'hF;
    for (int i = 0; i < 5; i++) step();
    step();
    check("sim_release", {8'd0, key_level, key_release}, 16'h0F);
    step();
    step();

    // Reset in the middle of a debounce count.
    key_in = 4'h0;
    step();
    step();
    rst_n = 1'b0;
    step();
    check("mid_rst", {key_level, key_press, key_release, key_long}, 16'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("post_rst_pre", {8'd0, key_level, key_press}, 16'd0);
    end
    step();
    check("post_rst_press", {8'd0, key_level, key_press}, 16'hFF);
    key_in = 4'hF;
    for (int i = 0; i < 8; i++) step();

    // Active-high polarity channel 3.
    key_in2 = 4'h8;
    for (int i = 0; i < 5; i++) begin
      step();
      check("pol_pre", {12'd0, press2}, 16'd0);
    end
    step();
    check("pol_press", {8'd0, level2, press2}, 16'h88);
    step();
    check("pol_pulse_end", {8'd0, level2, press2}, 16'h80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
